fibonacci_gen: RTL and testbench
================================

# fibonacci_gen

Parametrised Fibonacci-type sequence generator with a handshake. It emits up to `n_terms` terms of the recurrence x[k+2] = x[k+1] + x[k] from programmable seeds, on a valid/ready output stream. It detects overflow and either stops or wraps, depending on a mode parameter. It sits in the same datapath slot as the basic fixed-seed Fibonacci counter, adds back-pressure, term counting and completion signalling, and supersedes that counter.

## Interface

- `WIDTH`, 16: term width in bits.
- `CNT_W`, 8: width of the term count and term index.
- `OVF_MODE`, 0: 0 = stop on overflow, 1 = wrap modulo 2^WIDTH.

- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `seed0`  in  WIDTH  first term x[0]; sampled with `start`.
- `seed1`  in  WIDTH  second term x[1]; sampled with `start`.
- `n_terms`  in  CNT_W  number of terms to emit; sampled with `start`.
- `f_ready`  in  1  downstream accepts the current term.
- `f_valid`  out  1  `f_out` holds a valid term.
- `f_out`  out  WIDTH  current term.
- `f_idx`  out  CNT_W  index k of the current term.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a run ends.
- `overflow`  out  1  sticky overflow flag for the current or last run.

## Operation

**Registers**
- `ant`: current term, drives `f_out`.
- `pres`: next term.
- `pres_ovf`: carry out of the sum that produced `pres`.
- `idx`: term index, drives `f_idx`.
- Latched `n_terms`.
- FSM state.

**FSM: IDLE -> RUN -> DONE -> IDLE**
- IDLE, `start`=1:
  - Load `ant`=seed0, `pres`=seed1, `pres_ovf`=0, `idx`=0.
  - Clear `overflow`; latch `n_terms`.
  - Go to RUN, or to DONE if `n_terms`=0.
- RUN:
  - `f_valid`=1 and `busy`=1.
  - An accept is `f_valid & f_ready`. Without an accept, all registers hold.
- RUN, on accept with `idx` = `n_terms`-1: go to DONE.
- RUN, on accept with `pres_ovf`=1 and `OVF_MODE`=0:
  - Set `overflow`=1 and go to DONE.
  - The overflowed term is never emitted.
- RUN, on any other accept:
  - `ant`<=`pres`; `pres`<=low WIDTH bits of (`ant`+`pres`).
  - `pres_ovf`<=carry bit; `idx`<=`idx`+1.
  - If `OVF_MODE`=1 and the old `pres_ovf`=1 (so the new `ant` is a wrapped term), set `overflow`=1.
- DONE: `done`=1 for exactly one cycle, then unconditionally go to IDLE.

**Arithmetic**
- The sum is computed in WIDTH+1 bits. The carry bit is the overflow indicator.
- Seeds are unsigned. Carry from the seeds themselves is impossible, since no sum has been taken yet.

**Boundary conditions**
- `start` in RUN or DONE is ignored; there is no restart mid-run.
- `start` asserted in the same cycle as the DONE->IDLE transition is ignored. It is honoured only from IDLE.
- `n_terms`=1: exactly one term (seed0) is emitted.
- `n_terms`=0: no `f_valid`; `done` pulses one cycle after `start`.
- `n_terms` boundary and overflow on the same accept: the transition is to DONE, and `overflow`=1 only if `OVF_MODE`=0 and `pres_ovf`=1.
- `reset` asserted mid-run aborts immediately to IDLE with all reset values. No `done` pulse is generated.

## Timing

- Reset values: state IDLE; `f_valid`=0, `f_out`=0, `f_idx`=0, `busy`=0, `done`=0, `overflow`=0. `ant`, `pres` and `pres_ovf` are also 0.
- All outputs are registered or decoded from state; there are no combinational input-to-output paths.
- `start` sampled on edge N: `f_valid`=1 with `f_out`=seed0 from cycle N+1.
- Throughput is one term per cycle while `f_ready`=1.
- After an accept on edge M, the next term is on `f_out` from cycle M+1.
- The last accept on edge M gives `done`=1 in cycle M+1 and IDLE in cycle M+2.
- Hold rule: while `f_valid`=1 and `f_ready`=0, `f_out` and `f_idx` stay stable. `f_valid` never deasserts without an accept.
- `f_out` and `f_idx` keep their last values in IDLE and DONE.

## Test plan

- Basic run: seeds 0,1, `n_terms`=10, `f_ready`=1 → terms 0,1,1,2,3,5,8,13,21,34 on consecutive cycles; `f_idx` 0..9; `done` pulses one cycle after the last term; `overflow`=0.
- Lucas seeds: seeds 2,1, `n_terms`=6 → terms 2,1,3,4,7,11.
- Stop on overflow: WIDTH=16, `OVF_MODE`=0, seeds 0,1, `n_terms`=30 → 25 terms emitted, the last being 46368 at `f_idx`=24. 75025 is never emitted. `overflow`=1 and `done` pulses.
- Wrap on overflow: same run with `OVF_MODE`=1 → term 25 is 9489 (75025-65536). `overflow` rises in the cycle that term appears; all 30 terms are emitted.
- Back-pressure: toggle `f_ready` pseudo-randomly during the basic run → identical term sequence with no duplicates or drops; `f_out` stable while stalled.
- Edge and abort cases:
  - `n_terms`=0 → `done` pulse with no `f_valid`.
  - `start` during RUN → ignored.
  - `reset` low at term 4 → all outputs are 0 on the next sample, with no `done` pulse.
  - A new `start` then produces a fresh sequence from `f_idx`=0.

Source files
------------

// File: rtl/fibonacci_gen.sv
// fibonacci_gen: programmable-seed Fibonacci-type sequence generator.
// Emits up to n_terms terms of x[k+2] = x[k+1] + x[k] on a valid/ready
// stream. Overflow either ends the run (OVF_MODE=0) or wraps modulo
// 2^WIDTH (OVF_MODE=1). A one-cycle done pulse marks the end of each run.
module fibonacci_gen #(
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 8,
  parameter int OVF_MODE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             f_ready,
  output logic             f_valid,
  output logic [WIDTH-1:0] f_out,
  output logic [CNT_W-1:0] f_idx,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic WRAP_EN = (OVF_MODE != 0);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ant_q, ant_d;
  logic [WIDTH-1:0] pres_q, pres_d;
  logic             pres_ovf_q, pres_ovf_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] n_terms_q, n_terms_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH:0]   sum;
  logic             accept;
  logic             last_term;

  // The carry out of the WIDTH+1-bit sum flags that the next term no longer fits.
  assign sum       = {1'b0, ant_q} + {1'b0, pres_q};
  assign accept    = (state_q == ST_RUN) && f_ready;
  assign last_term = (idx_q == (n_terms_q - CNT_W'(1)));

  // Next-state and datapath update; every register holds unless an event moves it.
  always_comb begin
    state_d    = state_q;
    ant_d      = ant_q;
    pres_d     = pres_q;
    pres_ovf_d = pres_ovf_q;
    idx_d      = idx_q;
    n_terms_d  = n_terms_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ant_d      = seed0;
          pres_d     = seed1;
          pres_ovf_d = 1'b0;
          idx_d      = '0;
          n_terms_d  = n_terms;
          overflow_d = 1'b0;
          state_d    = (n_terms == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        if (accept) begin
          if (last_term) begin
            state_d = ST_DONE;
            if (!WRAP_EN && pres_ovf_q) begin
              overflow_d = 1'b1;
            end
          end else if (!WRAP_EN && pres_ovf_q) begin
            overflow_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            ant_d      = pres_q;
            pres_d     = sum[WIDTH-1:0];
            pres_ovf_d = sum[WIDTH];
            idx_d      = idx_q + CNT_W'(1);
            if (WRAP_EN && pres_ovf_q) begin
              overflow_d = 1'b1;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ant_q      <= '0;
      pres_q     <= '0;
      pres_ovf_q <= 1'b0;
      idx_q      <= '0;
      n_terms_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ant_q      <= ant_d;
      pres_q     <= pres_d;
      pres_ovf_q <= pres_ovf_d;
      idx_q      <= idx_d;
      n_terms_q  <= n_terms_d;
      overflow_q <= overflow_d;
    end
  end

  assign f_valid  = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign f_out    = ant_q;
  assign f_idx    = idx_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fibonacci_gen.sv
// tb_fibonacci_gen: directed self-checking bench for fibonacci_gen.
// Two instances share all inputs: dut stops on overflow, wdut wraps.
module tb_fibonacci_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed0 = '0;
  logic [15:0] seed1 = '0;
  logic [7:0]  n_terms = '0;
  logic        f_ready = 1'b0;

  logic        f_valid, busy, done, overflow;
  logic [15:0] f_out;
  logic [7:0]  f_idx;
  logic        w_valid, w_busy, w_done, w_overflow;
  logic [15:0] w_out;
  logic [7:0]  w_idx;

  int passed = 0;
  int total  = 0;

  fibonacci_gen #(.WIDTH(16), .CNT_W(8), .OVF_MODE(0)) dut (
    .clock(clock), .reset(reset), .start(start), .seed0(seed0), .seed1(seed1),
    .n_terms(n_terms), .f_ready(f_ready), .f_valid(f_valid), .f_out(f_out),
    .f_idx(f_idx), .busy(busy), .done(done), .overflow(overflow)
  );

  fibonacci_gen #(.WIDTH(16), .CNT_W(8), .OVF_MODE(1)) wdut (
    .clock(clock), .reset(reset), .start(start), .seed0(seed0), .seed1(seed1),
    .n_terms(n_terms), .f_ready(f_ready), .f_valid(w_valid), .f_out(w_out),
    .f_idx(w_idx), .busy(w_busy), .done(w_done), .overflow(w_overflow)
  );

  always #5 clock = ~clock;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [15:0] s0, input logic [15:0] s1, input logic [7:0] n);
    seed0   = s0;
    seed1   = s1;
    n_terms = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    f_ready = 1'b0;
    repeat (2) tick();
    total++; if (f_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", f_valid); else passed++;
    total++; if (f_out !== 16'd0) $display("[TB] FAIL reset_out: got %0d expected 0", f_out); else passed++;
    total++; if (f_idx !== 8'd0) $display("[TB] FAIL reset_idx: got %0d expected 0", f_idx); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %0b expected 0", done); else passed++;
    total++; if (overflow !== 1'b0) $display("[TB] FAIL reset_ovf: got %0b expected 0", overflow); else passed++;
    reset = 1'b1;
    tick();
    total++; if (f_valid !== 1'b0) $display("[TB] FAIL idle_valid: got %0b expected 0", f_valid); else passed++;
  endtask

  task automatic test_basic();
    int exp_b[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    f_ready = 1'b1;
    do_start(16'd0, 16'd1, 8'd10);
    total++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy: got %0b expected 1", busy); else passed++;
    for (int i = 0; i < 10; i++) begin
      total++; if (f_valid !== 1'b1) $display("[TB] FAIL basic_valid[%0d]: got %0b expected 1", i, f_valid); else passed++;
      total++; if (f_out !== 16'(exp_b[i])) $display("[TB] FAIL basic_out[%0d]: got %0d expected %0d", i, f_out, exp_b[i]); else passed++;
      total++; if (f_idx !== 8'(i)) $display("[TB] FAIL basic_idx[%0d]: got %0d expected %0d", i, f_idx, i); else passed++;
      tick();
    end
    total++; if (done !== 1'b1) $display("[TB] FAIL basic_done: got %0b expected 1", done); else passed++;
    total++; if (f_valid !== 1'b0) $display("[TB] FAIL basic_valid_end: got %0b expected 0", f_valid); else passed++;
    total++; if (overflow !== 1'b0) $display("[TB] FAIL basic_ovf: got %0b expected 0", overflow); else passed++;
    total++; if (f_out !== 16'd34) $display("[TB] FAIL basic_out_hold: got %0d expected 34", f_out); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("[TB] FAIL basic_done_pulse: got %0b expected 0", done); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL basic_idle_busy: got %0b expected 0", busy); else passed++;
  endtask

  task automatic test_lucas();
    int exp_l[6] = '{2, 1, 3, 4, 7, 11};
    f_ready = 1'b1;
    do_start(16'd2, 16'd1, 8'd6);
    for (int i = 0; i < 6; i++) begin
      total++; if (f_out !== 16'(exp_l[i])) $display("[TB] FAIL lucas_out[%0d]: got %0d expected %0d", i, f_out, exp_l[i]); else passed++;
      total++; if (f_idx !== 8'(i)) $display("[TB] FAIL lucas_idx[%0d]: got %0d expected %0d", i, f_idx, i); else passed++;
      tick();
    end
    total++; if (done !== 1'b1) $display("[TB] FAIL lucas_done: got %0b expected 1", done); else passed++;
    tick();
  endtask

  task automatic test_overflow();
    int fib[30];
    int s_cnt = 0, w_cnt = 0, s_done = 0, w_dn = 0;
    int s_last_out = -1, s_last_idx = -1;
    fib[0] = 0;
    fib[1] = 1;
    for (int k = 2; k < 30; k++) fib[k] = fib[k-1] + fib[k-2];
    f_ready = 1'b1;
    do_start(16'd0, 16'd1, 8'd30);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (f_valid) begin
        total++; if (int'(f_out) != fib[s_cnt]) $display("[TB] FAIL stop_out[%0d]: got %0d expected %0d", s_cnt, f_out, fib[s_cnt]); else passed++;
        total++; if (overflow !== 1'b0) $display("[TB] FAIL stop_ovf_early[%0d]: got %0b expected 0", s_cnt, overflow); else passed++;
        s_last_out = int'(f_out);
        s_last_idx = int'(f_idx);
        s_cnt++;
      end
      if (done) begin
        s_done++;
        total++; if (overflow !== 1'b1) $display("[TB] FAIL stop_ovf_done: got %0b expected 1", overflow); else passed++;
      end
      if (w_valid) begin
        total++; if (int'(w_out) != (fib[w_cnt] & 16'hFFFF)) $display("[TB] FAIL wrap_out[%0d]: got %0d expected %0d", w_cnt, w_out, fib[w_cnt] & 16'hFFFF); else passed++;
        total++; if (w_idx !== 8'(w_cnt)) $display("[TB] FAIL wrap_idx[%0d]: got %0d expected %0d", w_cnt, w_idx, w_cnt); else passed++;
        total++; if (w_overflow !== (w_cnt >= 25)) $display("[TB] FAIL wrap_ovf[%0d]: got %0b expected %0b", w_cnt, w_overflow, (w_cnt >= 25)); else passed++;
        if (w_cnt == 25) begin
          total++; if (w_out !== 16'd9489) $display("[TB] FAIL wrap_term25: got %0d expected 9489", w_out); else passed++;
        end
        w_cnt++;
      end
      if (w_done) w_dn++;
      tick();
    end
    total++; if (s_cnt != 25) $display("[TB] FAIL stop_count: got %0d expected 25", s_cnt); else passed++;
    total++; if (s_last_out != 46368) $display("[TB] FAIL stop_last_out: got %0d expected 46368", s_last_out); else passed++;
    total++; if (s_last_idx != 24) $display("[TB] FAIL stop_last_idx: got %0d expected 24", s_last_idx); else passed++;
    total++; if (s_done != 1) $display("[TB] FAIL stop_done_count: got %0d expected 1", s_done); else passed++;
    total++; if (overflow !== 1'b1) $display("[TB] FAIL stop_ovf_sticky: got %0b expected 1", overflow); else passed++;
    total++; if (w_cnt != 30) $display("[TB] FAIL wrap_count: got %0d expected 30", w_cnt); else passed++;
    total++; if (w_dn != 1) $display("[TB] FAIL wrap_done_count: got %0d expected 1", w_dn); else passed++;
  endtask

  task automatic test_backpressure();
    int exp_b[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    logic [31:0] pat = 32'b1011_0010_0111_0100_1101_1000_1110_0101;
    int cnt = 0;
    logic stalled = 1'b0;
    logic [15:0] prev_out = '0;
    f_ready = 1'b0;
    do_start(16'd0, 16'd1, 8'd10);
    for (int cyc = 0; cyc < 80 && cnt < 10; cyc++) begin
      f_ready = pat[cyc % 32];
      total++; if (f_valid !== 1'b1) $display("[TB] FAIL bp_valid[%0d]: got %0b expected 1", cyc, f_valid); else passed++;
      total++; if (f_out !== 16'(exp_b[cnt])) $display("[TB] FAIL bp_out[%0d]: got %0d expected %0d", cyc, f_out, exp_b[cnt]); else passed++;
      total++; if (f_idx !== 8'(cnt)) $display("[TB] FAIL bp_idx[%0d]: got %0d expected %0d", cyc, f_idx, cnt); else passed++;
      if (stalled) begin
        total++; if (f_out !== prev_out) $display("[TB] FAIL bp_hold[%0d]: got %0d expected %0d", cyc, f_out, prev_out); else passed++;
      end
      stalled  = !f_ready;
      prev_out = f_out;
      if (f_ready) cnt++;
      tick();
    end
    total++; if (cnt != 10) $display("[TB] FAIL bp_count: got %0d expected 10", cnt); else passed++;
    total++; if (done !== 1'b1) $display("[TB] FAIL bp_done: got %0b expected 1", done); else passed++;
    f_ready = 1'b1;
    tick();
  endtask

  task automatic test_edges();
    f_ready = 1'b1;
    do_start(16'd7, 16'd9, 8'd0);
    total++; if (done !== 1'b1) $display("[TB] FAIL n0_done: got %0b expected 1", done); else passed++;
    total++; if (f_valid !== 1'b0) $display("[TB] FAIL n0_valid: got %0b expected 0", f_valid); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("[TB] FAIL n0_done_pulse: got %0b expected 0", done); else passed++;
    total++; if (f_valid !== 1'b0) $display("[TB] FAIL n0_valid_idle: got %0b expected 0", f_valid); else passed++;

    do_start(16'd5, 16'd8, 8'd4);
    total++; if (f_out !== 16'd5) $display("[TB] FAIL run_start_t0: got %0d expected 5", f_out); else passed++;
    seed0   = 16'd100;
    seed1   = 16'd200;
    n_terms = 8'd9;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    total++; if (f_out !== 16'd8) $display("[TB] FAIL run_start_t1: got %0d expected 8", f_out); else passed++;
    total++; if (f_idx !== 8'd1) $display("[TB] FAIL run_start_idx1: got %0d expected 1", f_idx); else passed++;
    tick();
    total++; if (f_out !== 16'd13) $display("[TB] FAIL run_start_t2: got %0d expected 13", f_out); else passed++;
    tick();
    total++; if (f_out !== 16'd21) $display("[TB] FAIL run_start_t3: got %0d expected 21", f_out); else passed++;
    tick();
    total++; if (done !== 1'b1) $display("[TB] FAIL run_start_done: got %0b expected 1", done); else passed++;
    start = 1'b1;
    seed0 = 16'd1;
    seed1 = 16'd1;
    n_terms = 8'd5;
    tick();
    start = 1'b0;
    total++; if (f_valid !== 1'b0) $display("[TB] FAIL done_start_valid: got %0b expected 0", f_valid); else passed++;
    total++; if (done !== 1'b0) $display("[TB] FAIL done_start_done: got %0b expected 0", done); else passed++;
    tick();
    total++; if (f_valid !== 1'b0) $display("[TB] FAIL done_start_idle: got %0b expected 0", f_valid); else passed++;
  endtask

  task automatic test_abort();
    int done_seen = 0;
    int exp_a[3] = '{0, 1, 1};
    f_ready = 1'b1;
    do_start(16'd0, 16'd1, 8'd10);
    repeat (4) tick();
    total++; if (f_idx !== 8'd4) $display("[TB] FAIL abort_pre_idx: got %0d expected 4", f_idx); else passed++;
    total++; if (f_out !== 16'd3) $display("[TB] FAIL abort_pre_out: got %0d expected 3", f_out); else passed++;
    reset = 1'b0;
    #1;
    total++; if (f_valid !== 1'b0) $display("[TB] FAIL abort_valid: got %0b expected 0", f_valid); else passed++;
    total++; if (f_out !== 16'd0) $display("[TB] FAIL abort_out: got %0d expected 0", f_out); else passed++;
    total++; if (f_idx !== 8'd0) $display("[TB] FAIL abort_idx: got %0d expected 0", f_idx); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %0b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("[TB] FAIL abort_done: got %0b expected 0", done); else passed++;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) done_seen++;
    end
    total++; if (done_seen != 0) $display("[TB] FAIL abort_no_done: got %0d expected 0", done_seen); else passed++;
    do_start(16'd0, 16'd1, 8'd3);
    for (int i = 0; i < 3; i++) begin
      total++; if (f_out !== 16'(exp_a[i])) $display("[TB] FAIL fresh_out[%0d]: got %0d expected %0d", i, f_out, exp_a[i]); else passed++;
      total++; if (f_idx !== 8'(i)) $display("[TB] FAIL fresh_idx[%0d]: got %0d expected %0d", i, f_idx, i); else passed++;
      tick();
    end
    total++; if (done !== 1'b1) $display("[TB] FAIL fresh_done: got %0b expected 1", done); else passed++;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    test_reset();
    test_basic();
    test_lucas();
    test_overflow();
    test_backpressure();
    test_edges();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
